// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward AXI4-Stream FIFO feeding the AXIS processor.
// Buffers full beats {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}.
// Optional feature macro: AXIS_PACKET_FIFO_STORE_FWD_EN
//   defined   -> a packet is presented only after its tlast beat is stored;
//                packets longer than DEPTH cut through once the FIFO fills.
//   undefined -> plain FIFO; pkt_count is still maintained.
module axis_packet_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [31:0]       s_tdata,
    input  logic [3:0]        s_tstrb,
    input  logic [3:0]        s_tkeep,
    input  logic              s_tlast,
    input  logic [3:0]        s_tid,
    input  logic [3:0]        s_tdest,
    input  logic [3:0]        s_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [31:0]       m_tdata,
    output logic [3:0]        m_tstrb,
    output logic [3:0]        m_tkeep,
    output logic              m_tlast,
    output logic [3:0]        m_tid,
    output logic [3:0]        m_tdest,
    output logic [3:0]        m_tuser,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   pkt_count
);

    localparam int              ENTRY_W = 53;
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic               empty;
    logic               full;
    logic               wr_en;
    logic               rd_en;
    logic               wr_last;
    logic               rd_last;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign s_tready = !full && !arst;
    assign wr_en    = s_tvalid && s_tready;
    assign rd_en    = m_tvalid && m_tready;
    assign wr_last  = wr_en && s_tlast;
    assign rd_last  = rd_en && m_tlast;

    // Pointer difference wraps naturally in ADDR_W+1 bits, giving 0..DEPTH.
    assign level = wr_ptr - rd_ptr;

    assign head = mem[rd_ptr[ADDR_W-1:0]];
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = head;

    // Beat storage; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_tdata, s_tstrb, s_tkeep, s_tlast,
                                        s_tid, s_tdest, s_tuser};
        end
    end

    // Write and read pointers, MSB acts as the wrap bit.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (rd_en) rd_ptr <= rd_ptr + ONE;
        end
    end

    // Complete packets held: tlast in increments, tlast out decrements.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pkt_count <= '0;
        end else if (wr_last && !rd_last) begin
            pkt_count <= pkt_count + ONE;
        end else if (rd_last && !wr_last) begin
            pkt_count <= pkt_count - ONE;
        end
    end

`ifdef AXIS_PACKET_FIFO_STORE_FWD_EN
    logic flush;

    // Oversize escape: once full with no complete packet, the head packet
    // drains cut-through until its tlast beat leaves.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            flush <= 1'b0;
        end else if (rd_last) begin
            flush <= 1'b0;
        end else if (full && (pkt_count == '0)) begin
            flush <= 1'b1;
        end
    end

    assign m_tvalid = !empty && ((pkt_count != '0) || full || flush);
`else
    assign m_tvalid = !empty;
`endif

endmodule
